// File: rtl/data_mem_responder.sv
// Word-array data memory that answers one request at a time after WAIT_STATES idle cycles.
// Optional misaligned-access fault reporting is enabled by defining MEM_MISALIGN_FAULT_EN.
module data_mem_responder #(
  parameter int DEPTH_WORDS = 64,
  parameter int WAIT_STATES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemReady,
  output logic        MemBusy,
  output logic        MemFault
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  logic [1:0]       state_q, state_d;
  logic [3:0]       wait_cnt_q, wait_cnt_d;
  logic             wr_q;
  logic [IDX_W-1:0] idx_q;
  logic [31:0]      wdata_q;
  logic             mis_q;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             fault_q, fault_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [31:0]      mem_q [DEPTH_WORDS];

  logic             capture;
  logic             enter_resp;
  logic             commit;
  logic             cap_mis;
  logic [IDX_W-1:0] cap_idx;
  logic [IDX_W-1:0] req_idx;
  logic             req_write;
  logic             req_mis;
  logic             unused_addr_bits;

  assign cap_idx = ALUResult[IDX_W+1:2];

`ifdef MEM_MISALIGN_FAULT_EN
  assign cap_mis          = (ALUResult[1:0] != 2'b00);
  assign unused_addr_bits = ^ALUResult[31:IDX_W+2];
`else
  assign cap_mis          = 1'b0;
  assign unused_addr_bits = ^{ALUResult[31:IDX_W+2], ALUResult[1:0]};
`endif

  assign capture = (state_q == ST_IDLE) && MemReq;

  // With zero wait states the response is formed on the capture edge itself,
  // so the request attributes come straight from the inputs in that case.
  assign req_idx   = capture ? cap_idx  : idx_q;
  assign req_write = capture ? MemWrite : wr_q;
  assign req_mis   = capture ? cap_mis  : mis_q;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (MemReq) begin
          if (WAIT_STATES > 0) begin
            state_d    = ST_WAIT;
            wait_cnt_d = WAIT_LOAD;
          end else begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WAIT: begin
        if (wait_cnt_q == 4'd0) begin
          state_d = ST_RESP;
        end else begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign enter_resp = (state_d == ST_RESP) && (state_q != ST_RESP);
  assign commit     = (state_q == ST_RESP) && wr_q && !mis_q;

  always_comb begin
    ready_d = enter_resp;
    busy_d  = (state_d != ST_IDLE);
    fault_d = enter_resp && req_mis;
    rdata_d = '0;
    if (enter_resp && !req_write && !req_mis) begin
      rdata_d = mem_q[req_idx];
    end
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      wait_cnt_q <= 4'd0;
      wr_q       <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      mis_q      <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      fault_q    <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      fault_q    <= fault_d;
      rdata_q    <= rdata_d;
      if (capture) begin
        wr_q    <= MemWrite;
        idx_q   <= cap_idx;
        wdata_q <= WriteData;
        mis_q   <= cap_mis;
      end
    end
  end

  // NOTE: the word array has no reset so it maps onto plain RAM and survives reset;
  // an aborted store cannot commit because reset forces the state out of RESP.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem_q[idx_q] <= wdata_q;
    end
  end

  assign ReadData = rdata_q;
  assign MemReady = ready_q;
  assign MemBusy  = busy_q;
  assign MemFault = fault_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: two instances (0 and 2 wait states) share one stimulus,
// a transaction-level model predicts every cycle, and directed loads pin known values.
module tb_data_mem_responder;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        req   = 1'b0;
  logic        wr    = 1'b0;
  logic [31:0] addr  = '0;
  logic [31:0] wdata = '0;

  logic [31:0] rdata [2];
  logic        ready [2];
  logic        busy  [2];
  logic        fault [2];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .reset(reset), .MemReq(req), .MemWrite(wr), .ALUResult(addr),
    .WriteData(wdata), .ReadData(rdata[0]), .MemReady(ready[0]), .MemBusy(busy[0]),
    .MemFault(fault[0])
  );

  data_mem_responder #(.DEPTH_WORDS(64), .WAIT_STATES(2)) u_dut2 (
    .clk(clk), .reset(reset), .MemReq(req), .MemWrite(wr), .ALUResult(addr),
    .WriteData(wdata), .ReadData(rdata[1]), .MemReady(ready[1]), .MemBusy(busy[1]),
    .MemFault(fault[1])
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 2;
  endfunction

  function automatic logic misaligned(input logic [31:0] a);
`ifdef MEM_MISALIGN_FAULT_EN
    return (a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Transaction model: one pending request per instance, answered WS cycles after capture.
  logic        m_pend [2];
  int          m_cap  [2];
  logic        m_wr   [2];
  logic [5:0]  m_idx  [2];
  logic [31:0] m_data [2];
  logic        m_mis  [2];
  logic [31:0] m_mem  [2][64];
  logic        e_ready [2];
  logic        e_busy  [2];
  logic        e_fault [2];
  logic [31:0] e_rdata [2];
  int          edge_n = 0;

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_pend[d]  = 1'b0;
      e_ready[d] = 1'b0;
      e_busy[d]  = 1'b0;
      e_fault[d] = 1'b0;
      e_rdata[d] = '0;
    end
  endtask

  task automatic model_edge();
    edge_n++;
    for (int d = 0; d < 2; d++) begin
      if (!m_pend[d] && req) begin
        m_pend[d] = 1'b1;
        m_cap[d]  = edge_n;
        m_wr[d]   = wr;
        m_idx[d]  = addr[7:2];
        m_data[d] = wdata;
        m_mis[d]  = misaligned(addr);
      end else if (m_pend[d] && edge_n == m_cap[d] + ws_of(d) + 1) begin
        if (m_wr[d] && !m_mis[d]) m_mem[d][m_idx[d]] = m_data[d];
        m_pend[d] = 1'b0;
      end
      e_busy[d]  = m_pend[d];
      e_ready[d] = m_pend[d] && (edge_n == m_cap[d] + ws_of(d));
      e_fault[d] = e_ready[d] && m_mis[d];
      e_rdata[d] = (e_ready[d] && !m_wr[d] && !m_mis[d]) ? m_mem[d][m_idx[d]] : 32'h0;
    end
  endtask

  initial begin
    model_clear();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_clear();
      else        model_edge();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        check($sformatf("ready_dut%0d", d), 32'(ready[d]), 32'(e_ready[d]));
        check($sformatf("busy_dut%0d",  d), 32'(busy[d]),  32'(e_busy[d]));
        check($sformatf("fault_dut%0d", d), 32'(fault[d]), 32'(e_fault[d]));
        check($sformatf("rdata_dut%0d", d), rdata[d], e_rdata[d]);
      end
    end
  end

  int npulse [2] = '{0, 0};
  initial begin
    forever begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) if (ready[d]) npulse[d]++;
    end
  end

  int          lat   [2];
  int          nbusy [2];
  logic [31:0] rd    [2];
  logic        flt   [2];

  task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] dat);
    @(posedge clk); #1;
    req = 1'b1; wr = w; addr = a; wdata = dat;
    @(posedge clk); #1;
    req = 1'b0;
    for (int d = 0; d < 2; d++) begin
      lat[d] = 0; nbusy[d] = 0; rd[d] = '0; flt[d] = 1'b0;
    end
    for (int k = 1; k <= 20 && !(lat[0] != 0 && lat[1] != 0); k++) begin
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
        if (lat[d] == 0 && busy[d]) nbusy[d]++;
        if (lat[d] == 0 && ready[d]) begin
          lat[d] = k; rd[d] = rdata[d]; flt[d] = fault[d];
        end
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (lat[d] == 0) begin
        checks++; failures++;
        $display("FAIL timeout_dut%0d: no MemReady within 20 cycles of capture", d);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("reset_ready%0d", d), 32'(ready[d]), 32'h0);
      check($sformatf("reset_busy%0d",  d), 32'(busy[d]),  32'h0);
      check($sformatf("reset_fault%0d", d), 32'(fault[d]), 32'h0);
      check($sformatf("reset_rdata%0d", d), rdata[d], 32'h0);
    end
    #2 reset = 1'b1;

    do_txn(1'b1, 32'h10, 32'hDEADBEEF);
    check("st_lat_ws0",   32'(lat[0]),   32'd1);
    check("st_lat_ws2",   32'(lat[1]),   32'd3);
    check("st_busy_ws0",  32'(nbusy[0]), 32'd1);
    check("st_busy_ws2",  32'(nbusy[1]), 32'd3);
    check("st_rdata_ws0", rd[0], 32'h0);
    check("st_rdata_ws2", rd[1], 32'h0);

    do_txn(1'b0, 32'h10, 32'h0);
    check("ld10_lat_ws2", 32'(lat[1]), 32'd3);
    check("ld10_ws0", rd[0], 32'hDEADBEEF);
    check("ld10_ws2", rd[1], 32'hDEADBEEF);

    do_txn(1'b1, 32'h04, 32'h12345678);
    do_txn(1'b0, 32'h04, 32'h0);
    check("ld04_lat_ws0",  32'(lat[0]),   32'd1);
    check("ld04_busy_ws0", 32'(nbusy[0]), 32'd1);
    check("ld04_ws0", rd[0], 32'h12345678);
    check("ld04_ws2", rd[1], 32'h12345678);

    do_txn(1'b1, 32'h100, 32'hA5A5A5A5);
    do_txn(1'b0, 32'h000, 32'h0);
    check("wrap_ws0", rd[0], 32'hA5A5A5A5);
    check("wrap_ws2", rd[1], 32'hA5A5A5A5);

    // Request held high; address/data change while the first request is in flight.
    npulse[0] = 0; npulse[1] = 0;
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 32'h40; wdata = 32'h0BADF00D;
    @(posedge clk); #1;
    addr = 32'h44; wdata = 32'h55555555;
    repeat (5) @(posedge clk);
    #1 req = 1'b0;
    repeat (6) @(posedge clk);
    check("held_pulses_ws0", 32'(npulse[0]), 32'd3);
    check("held_pulses_ws2", 32'(npulse[1]), 32'd2);
    do_txn(1'b0, 32'h40, 32'h0);
    check("held40_ws0", rd[0], 32'h0BADF00D);
    check("held40_ws2", rd[1], 32'h0BADF00D);
    do_txn(1'b0, 32'h44, 32'h0);
    check("held44_ws0", rd[0], 32'h55555555);
    check("held44_ws2", rd[1], 32'h55555555);

    // Store aborted by reset while in flight must leave the old word intact.
    do_txn(1'b1, 32'h20, 32'hCAFEF00D);
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; addr = 32'h20; wdata = 32'h11111111;
    @(posedge clk); #1;
    req = 1'b0;
    @(negedge clk); #2;
    reset = 1'b0;
    #1;
    for (int d = 0; d < 2; d++) begin
      check($sformatf("abort_ready%0d", d), 32'(ready[d]), 32'h0);
      check($sformatf("abort_busy%0d",  d), 32'(busy[d]),  32'h0);
      check($sformatf("abort_rdata%0d", d), rdata[d], 32'h0);
    end
    @(negedge clk); #2;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    do_txn(1'b0, 32'h20, 32'h0);
    check("abort_ld_ws0", rd[0], 32'hCAFEF00D);
    check("abort_ld_ws2", rd[1], 32'hCAFEF00D);

    do_txn(1'b1, 32'h22, 32'h77777777);
`ifdef MEM_MISALIGN_FAULT_EN
    check("mis_fault_ws0", 32'(flt[0]), 32'h1);
    check("mis_fault_ws2", 32'(flt[1]), 32'h1);
    do_txn(1'b0, 32'h20, 32'h0);
    check("mis_keep_ws0", rd[0], 32'hCAFEF00D);
    check("mis_keep_ws2", rd[1], 32'hCAFEF00D);
    do_txn(1'b0, 32'h21, 32'h0);
    check("mis_ld_fault_ws2", 32'(flt[1]), 32'h1);
    check("mis_ld_rdata_ws2", rd[1], 32'h0);
`else
    check("mis_fault_ws0", 32'(flt[0]), 32'h0);
    check("mis_fault_ws2", 32'(flt[1]), 32'h0);
    do_txn(1'b0, 32'h20, 32'h0);
    check("mis_commit_ws0", rd[0], 32'h77777777);
    check("mis_commit_ws2", rd[1], 32'h77777777);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
